// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with async clear, optional zero register,
// optional write-to-read forwarding and a per-register busy scoreboard.
module regfile_bypass #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     ADDR_W    = 5,
    parameter bit              ZERO_REG  = 1'b1,
    parameter bit              BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] RW,
    input  logic [WIDTH-1:0]  busW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]  busA,
    output logic [WIDTH-1:0]  busB,
    input  logic              SET,
    input  logic [ADDR_W-1:0] SA,
    output logic              busyA,
    output logic              busyB
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             set_ok;
    logic             fwd;

    assign wr_ok  = WE  && !(ZERO_REG && (RW == '0));
    assign set_ok = SET && !(ZERO_REG && (SA == '0));
    // rst_n gates forwarding so outputs show the cleared state during reset
    assign fwd    = BYPASS && rst_n && wr_ok;

    always_comb begin
        busy_d = busy_q;
        if (wr_ok)  busy_d[RW] = 1'b0;
        if (set_ok) busy_d[SA] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) regs_q[RW] <= busW;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busA  = regs_q[RA];
        busB  = regs_q[RB];
        busyA = busy_q[RA];
        busyB = busy_q[RB];
        if (fwd && (RA == RW)) begin
            busA = busW;
            if (!(SET && (SA == RA))) busyA = 1'b0;
        end
        if (fwd && (RB == RW)) begin
            busB = busW;
            if (!(SET && (SA == RB))) busyB = 1'b0;
        end
        if (ZERO_REG && (RA == '0)) begin
            busA  = '0;
            busyA = 1'b0;
        end
        if (ZERO_REG && (RB == '0)) begin
            busB  = '0;
            busyB = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: a behavioural register/busy model checked
// every cycle on bypass and non-bypass instances, plus literal spot checks.
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WE = 1'b0, SET = 1'b0;
    logic [4:0]  RW = '0, RA = '0, RB = '0, SA = '0;
    logic [31:0] busW = '0;
    logic [31:0] busA, busB, nbusA, nbusB;
    logic        busyA, busyB, nbusyA, nbusyB;

    logic        wWE = 1'b0, wSET = 1'b0;
    logic [2:0]  wRW = '0, wRA = '0, wRB = '0, wSA = '0;
    logic [63:0] wbusW = '0, wbusA, wbusB;
    logic        wbusyA, wbusyB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_bypass dut (
        .clk(clk), .rst_n(rst_n), .WE(WE), .RW(RW), .busW(busW), .RA(RA), .RB(RB),
        .busA(busA), .busB(busB), .SET(SET), .SA(SA), .busyA(busyA), .busyB(busyB)
    );

    regfile_bypass #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .WE(WE), .RW(RW), .busW(busW), .RA(RA), .RB(RB),
        .busA(nbusA), .busB(nbusB), .SET(SET), .SA(SA), .busyA(nbusyA), .busyB(nbusyB)
    );

    regfile_bypass #(.WIDTH(64), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1),
                     .RESET_VAL(64'hDEAD)) dut_w (
        .clk(clk), .rst_n(rst_n), .WE(wWE), .RW(wRW), .busW(wbusW), .RA(wRA), .RB(wRB),
        .busA(wbusA), .busB(wbusB), .SET(wSET), .SA(wSA), .busyA(wbusyA), .busyB(wbusyB)
    );

    // Reference state for the two 32-bit instances (they share inputs and storage)
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (WE && RW != 5'd0) begin
                m_regs[RW] <= busW;
                m_busy[RW] <= 1'b0;
            end
            if (SET && SA != 5'd0) m_busy[SA] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && rst_n && WE && RW == a) return busW;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && rst_n && WE && RW == a && !(SET && SA == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busA",   {32'd0, busA},   {32'd0, exp_data(RA, 1'b1)});
        chk("busB",   {32'd0, busB},   {32'd0, exp_data(RB, 1'b1)});
        chk("busyA",  {63'd0, busyA},  {63'd0, exp_busy(RA, 1'b1)});
        chk("busyB",  {63'd0, busyB},  {63'd0, exp_busy(RB, 1'b1)});
        chk("nbusA",  {32'd0, nbusA},  {32'd0, exp_data(RA, 1'b0)});
        chk("nbusB",  {32'd0, nbusB},  {32'd0, exp_data(RB, 1'b0)});
        chk("nbusyA", {63'd0, nbusyA}, {63'd0, exp_busy(RA, 1'b0)});
        chk("nbusyB", {63'd0, nbusyB}, {63'd0, exp_busy(RB, 1'b0)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Write attempted during reset must be ignored
        WE = 1'b1; RW = 5'd1; busW = 32'h3F; RA = 5'd1; RB = 5'd1;
        tick(); tick();
        chk("rst_busA",  {32'd0, busA},  64'd0);
        chk("rst_busyA", {63'd0, busyA}, 64'd0);
        chk("rst_wbusA", wbusA, 64'd0);
        rst_n = 1'b1;
        WE = 1'b0;
        #1;
        chk("post_rst_busA", {32'd0, busA}, 64'd0);

        WE = 1'b1; RW = 5'd1; busW = 32'h3F; tick();
        RW = 5'd2; busW = 32'h3; tick();
        WE = 1'b0; RA = 5'd1; RB = 5'd2; #1;
        chk("rd_r1", {32'd0, busA}, 64'h3F);
        chk("rd_r2", {32'd0, busB}, 64'h3);
        repeat (5) tick();
        chk("hold_r1", {32'd0, nbusA}, 64'h3F);
        chk("hold_r2", {32'd0, nbusB}, 64'h3);

        WE = 1'b1; RW = 5'd0; busW = 32'hFFFF_FFFF; RA = 5'd0; #1;
        chk("r0_byp", {32'd0, busA}, 64'd0);
        tick(); WE = 1'b0; #1;
        chk("r0_wr",    {32'd0, busA},  64'd0);
        chk("r0_wr_nb", {32'd0, nbusA}, 64'd0);

        WE = 1'b1; RW = 5'd5; RA = 5'd5; busW = 32'hA5A5_A5A5; #1;
        chk("byp_r5",  {32'd0, busA},  64'hA5A5_A5A5);
        chk("nbyp_r5", {32'd0, nbusA}, 64'd0);
        tick(); WE = 1'b0; #1;
        chk("nbyp_r5_after", {32'd0, nbusA}, 64'hA5A5_A5A5);

        SET = 1'b1; SA = 5'd7; tick();
        SET = 1'b0; RA = 5'd7; #1;
        chk("busy7",    {63'd0, busyA},  64'd1);
        chk("busy7_nb", {63'd0, nbusyA}, 64'd1);
        WE = 1'b1; RW = 5'd7; busW = 32'h77; #1;
        chk("busy7_byp",    {63'd0, busyA},  64'd0);
        chk("busy7_nobyp",  {63'd0, nbusyA}, 64'd1);
        tick(); WE = 1'b0; #1;
        chk("busy7_clr", {63'd0, nbusyA}, 64'd0);
        SET = 1'b1; SA = 5'd7; WE = 1'b1; RW = 5'd7; busW = 32'h78; tick();
        SET = 1'b0; WE = 1'b0; #1;
        chk("busy7_setwins", {63'd0, busyA}, 64'd1);
        SET = 1'b1; SA = 5'd0; tick();
        SET = 1'b0; RA = 5'd0; #1;
        chk("busy0", {63'd0, busyA}, 64'd0);

        WE = 1'b1; RW = 5'd3; busW = 32'h1234; SET = 1'b1; SA = 5'd3; tick();
        WE = 1'b0; SET = 1'b0; RA = 5'd3; #1;
        chk("r3",     {32'd0, busA},  64'h1234);
        chk("busy3",  {63'd0, busyA}, 64'd1);
        rst_n = 1'b0; #1;
        chk("async_busA",  {32'd0, busA},  64'd0);
        chk("async_busyA", {63'd0, busyA}, 64'd0);
        WE = 1'b1; RW = 5'd4; busW = 32'h55; RB = 5'd4; tick();
        rst_n = 1'b1; WE = 1'b0; #1;
        chk("lost_wr_r4", {32'd0, busB}, 64'd0);

        wWE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wRA = 3'(i); #1;
            chk("w_reset", wbusA, (i == 0) ? 64'd0 : 64'hDEAD);
        end
        wWE = 1'b1; wRW = 3'd7; wbusW = '1; tick();
        wWE = 1'b0; wRA = 3'd7; wRB = 3'd7; #1;
        chk("w_r7_A", wbusA, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w_r7_B", wbusB, 64'hFFFF_FFFF_FFFF_FFFF);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
